// File: rtl/freespeech_pkg.sv
// Shared types and default parameters for the freespeech message sequencer.
package freespeech_pkg;

  localparam int unsigned DEPTH_DEFAULT     = 8;
  localparam int unsigned RATE_BASE_DEFAULT = 10;
  localparam int unsigned RATE_W_DEFAULT    = 3;

  localparam int unsigned PTR_W = $clog2(DEPTH_DEFAULT);
  localparam int unsigned LEN_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [LEN_W-1:0] len_t;
  typedef logic [3:0]       nibble_t;

  // Divider width needed to reach 2^(rate+rate_base)-1 for the largest rate.
  function automatic int unsigned div_width(int unsigned rate_base, int unsigned rate_w);
    return rate_base + (32'd1 << rate_w) - 32'd1;
  endfunction

endpackage

// File: rtl/freespeech_rate_div.sv
// Step-period divider: raises tick on the last cycle of each 2^(rate+RATE_BASE) period.
module freespeech_rate_div
  import freespeech_pkg::*;
#(
  parameter int unsigned RATE_BASE = RATE_BASE_DEFAULT,
  parameter int unsigned RATE_W    = RATE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate,
  input  logic              clear,
  output logic              tick
);

  localparam int unsigned DIV_W = div_width(RATE_BASE, RATE_W);
  localparam int unsigned LIM_W = DIV_W + 1;

  logic [DIV_W-1:0] div_q;
  logic [LIM_W-1:0] limit;

  // >= rather than == so a rate decrease mid-count still terminates promptly.
  always_comb begin
    limit = (LIM_W'(1) << (32'(rate) + RATE_BASE)) - LIM_W'(1);
    tick  = enable && ({1'b0, div_q} >= limit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (clear || !enable || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/freespeech_sequencer.sv
// Nibble message store with periodic wrapping playback feeding a hex-to-7-segment decoder.
// Optional FREESPEECH_SEQ_BLANK_GAP_EN inserts one blank step period after the last character.
module freespeech_sequencer
  import freespeech_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEFAULT,
  parameter int unsigned RATE_BASE = RATE_BASE_DEFAULT,
  parameter int unsigned RATE_W    = RATE_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [3:0]             wr_data,
  input  logic                   clear,
  input  logic                   run,
  input  logic [RATE_W-1:0]      rate,
  output logic [3:0]             hex,
  output logic                   valid,
  output logic                   step,
  output logic [$clog2(DEPTH):0] length,
  output logic                   full
);

  localparam int unsigned P_W = $clog2(DEPTH);
  localparam int unsigned L_W = P_W + 1;

  nibble_t        mem [DEPTH];
  logic [P_W-1:0] rd_ptr;
  logic [L_W-1:0] len_q;
  logic           step_q;
  logic           gap_c;
  logic           active_c;
  logic           last_c;
  logic           wr_ok_c;
  logic           tick;

`ifdef FREESPEECH_SEQ_BLANK_GAP_EN
  logic gap_q;
  assign gap_c = gap_q;
`else
  assign gap_c = 1'b0;
`endif

  always_comb begin
    active_c = run && (len_q != '0);
    last_c   = (L_W'(rd_ptr) == (len_q - L_W'(1)));
    full     = (len_q == L_W'(DEPTH));
    wr_ok_c  = wr_en && !clear && !full;
    valid    = active_c && !gap_c;
    length   = len_q;
    step     = step_q;
    hex      = ((len_q == '0) || gap_c) ? 4'h0 : mem[rd_ptr];
  end

  freespeech_rate_div #(
    .RATE_BASE (RATE_BASE),
    .RATE_W    (RATE_W)
  ) u_rate_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (active_c),
    .rate   (rate),
    .clear  (clear),
    .tick   (tick)
  );

  // Message storage carries no reset; entries beyond length are never shown.
  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      mem[len_q[P_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      rd_ptr <= '0;
      step_q <= 1'b0;
    end else if (clear) begin
      len_q  <= '0;
      rd_ptr <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= tick;
      if (wr_ok_c) begin
        len_q <= len_q + L_W'(1);
      end
      if (tick) begin
        if (last_c || gap_c) begin
          rd_ptr <= '0;
        end else begin
          rd_ptr <= rd_ptr + P_W'(1);
        end
      end
    end
  end

`ifdef FREESPEECH_SEQ_BLANK_GAP_EN
  // Gap is entered from the last character and left after one full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= 1'b0;
    end else if (clear || !active_c) begin
      gap_q <= 1'b0;
    end else if (tick) begin
      gap_q <= !gap_q && last_c;
    end
  end
`endif

endmodule

// File: tb/tb_freespeech_sequencer.sv
// Directed bench for freespeech_sequencer with a queue-based message/playback model.
module tb_freespeech_sequencer;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned RATE_BASE = 0;
  localparam int unsigned RATE_W    = 3;
`ifdef FREESPEECH_SEQ_BLANK_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       clear;
  logic       run;
  logic [2:0] rate;
  logic [3:0] hex;
  logic       valid;
  logic       step;
  logic [3:0] length;
  logic       full;

  freespeech_sequencer #(
    .DEPTH     (DEPTH),
    .RATE_BASE (RATE_BASE),
    .RATE_W    (RATE_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .clear   (clear),
    .run     (run),
    .rate    (rate),
    .hex     (hex),
    .valid   (valid),
    .step    (step),
    .length  (length),
    .full    (full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_pass;

  // Model: message as a queue, position in it, cycles spent in the current period.
  int m_msg[$];
  int m_pos;
  int m_elapsed;
  int m_period;
  bit m_gap;
  bit m_step;
  bit m_act;
  bit m_tk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      m_msg.delete();
      m_pos     = 0;
      m_elapsed = 0;
      m_gap     = 1'b0;
      m_step    = 1'b0;
    end else begin
      m_act    = run && (m_msg.size() > 0);
      m_period = 1 << (int'(rate) + RATE_BASE);
      m_tk     = m_act && (m_elapsed + 1 >= m_period);
      if (m_tk) begin
        m_elapsed = 0;
        if (GAP_EN && m_gap) begin
          m_gap = 1'b0;
          m_pos = 0;
        end else if (m_pos == m_msg.size() - 1) begin
          m_gap = GAP_EN;
          m_pos = 0;
        end else begin
          m_pos = m_pos + 1;
        end
      end else begin
        m_elapsed = m_act ? m_elapsed + 1 : 0;
      end
      if (!m_act) m_gap = 1'b0;
      m_step = m_tk;
      if (wr_en && m_msg.size() < DEPTH) m_msg.push_back(int'(wr_data));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic compare_model();
    int eh;
    bit ev;
    eh = (m_msg.size() == 0 || m_gap) ? 0 : m_msg[m_pos];
    ev = run && (m_msg.size() > 0) && !m_gap;
    check("model_hex",    32'(hex),    32'(eh));
    check("model_valid",  32'(valid),  32'(ev));
    check("model_step",   32'(step),   32'(m_step));
    check("model_length", 32'(length), 32'(m_msg.size()));
    check("model_full",   32'(full),   32'(m_msg.size() == DEPTH));
  endtask

  // Advance to the next falling edge and compare every output against the model.
  task automatic cycle();
    @(negedge clk);
    if (rst_n) compare_model();
  endtask

  int seq_hex[7]  = '{3, 1, 1, 4, 4, 3, 3};
  int seq_step[7] = '{0, 1, 0, 1, 0, 1, 0};
  int seq_gap_hex[4]   = '{0, 10, 11, 0};
  int seq_gap_valid[4] = '{0, 1, 1, 0};
  int seq_nogap_hex[4] = '{10, 11, 10, 11};

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 4'h0;
    clear   = 1'b0;
    run     = 1'b0;
    rate    = 3'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("rst_hex",    32'(hex),    32'd0);
    check("rst_valid",  32'(valid),  32'd0);
    check("rst_length", 32'(length), 32'd0);
    check("rst_full",   32'(full),   32'd0);

    // Load 3,1,4 while stopped.
    wr_en = 1'b1;
    wr_data = 4'd3; cycle();
    wr_data = 4'd1; cycle();
    wr_data = 4'd4; cycle();
    wr_en = 1'b0;
    cycle();
    check("load_length", 32'(length), 32'd3);
    check("load_hex",    32'(hex),    32'd3);
    check("load_valid",  32'(valid),  32'd0);

    // Period-2 playback with wrap 4 -> 3.
    run  = 1'b1;
    rate = 3'd1;
    for (int i = 0; i < 7; i++) begin
      cycle();
      check($sformatf("play_hex[%0d]", i),  32'(hex),  32'(seq_hex[i]));
      check($sformatf("play_step[%0d]", i), 32'(step), 32'(seq_step[i]));
    end

    // Asynchronous reset in the middle of a low clock phase.
    #3 rst_n = 1'b0;
    #1;
    check("arst_hex",    32'(hex),    32'd0);
    check("arst_valid",  32'(valid),  32'd0);
    check("arst_step",   32'(step),   32'd0);
    check("arst_length", 32'(length), 32'd0);
    check("arst_full",   32'(full),   32'd0);
    @(negedge clk);
    run   = 1'b0;
    rst_n = 1'b1;
    cycle();

    // Nine writes: eighth fills, ninth ignored.
    wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_data = 4'(i);
      cycle();
      if (i == 7) check("fill_full", 32'(full), 32'd1);
    end
    wr_en = 1'b0;
    check("fill_length", 32'(length), 32'd8);
    check("fill_hex0",   32'(hex),    32'd0);
    run  = 1'b1;
    rate = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check($sformatf("full_play_hex[%0d]", i), 32'(hex), 32'((i + 1) % 8));
    end

    // clear wins over a simultaneous write.
    clear   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 4'hf;
    cycle();
    check("clr_length", 32'(length), 32'd0);
    check("clr_valid",  32'(valid),  32'd0);
    check("clr_hex",    32'(hex),    32'd0);
    clear = 1'b0;
    wr_en = 1'b0;
    cycle();
    check("clr_hold_length", 32'(length), 32'd0);

    // Two-entry message, rate drops 3 -> 0 with divider at 5.
    run   = 1'b0;
    wr_en = 1'b1;
    wr_data = 4'ha; cycle();
    wr_data = 4'hb; cycle();
    wr_en = 1'b0;
    run  = 1'b1;
    rate = 3'd3;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("slow_nostep[%0d]", i), 32'(step), 32'd0);
    end
    rate = 3'd0;
    cycle();
    check("ratedrop_step", 32'(step), 32'd1);
    check("ratedrop_hex",  32'(hex),  32'hb);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("tail_step[%0d]", i), 32'(step), 32'd1);
      if (GAP_EN) begin
        check($sformatf("gap_hex[%0d]", i),   32'(hex),   32'(seq_gap_hex[i]));
        check($sformatf("gap_valid[%0d]", i), 32'(valid), 32'(seq_gap_valid[i]));
      end else begin
        check($sformatf("wrap_hex[%0d]", i),   32'(hex),   32'(seq_nogap_hex[i]));
        check($sformatf("wrap_valid[%0d]", i), 32'(valid), 32'd1);
      end
    end

    // Stop mid-period, then restart a full period.
    run  = 1'b0;
    rate = 3'd2;
    cycle();
    check("stop_valid", 32'(valid), 32'd0);
    run = 1'b1;
    repeat (10) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
